run_cmd_parser: RTL and testbench



---
 rtl/run_cmd_parser.sv | 160 ++++++++++++++++
 tb/tb_run_cmd_parser.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/run_cmd_parser.sv
// ASCII run-control command parser: 'g [hex]' (go) and 'q' (quit), CR/LF terminated.
// Optional macro RUN_CMD_STEP_EN adds the 's' single-step command.
module run_cmd_parser #(
  parameter logic [31:0] INIT_ADR   = 32'h0000_0000,
  parameter int unsigned MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  input  logic        cpu_run_state,
  output logic        cpu_start,
  output logic        quit_cmd,
  output logic [29:0] start_adr,
  output logic        cmd_err,
  output logic        parser_busy
);

`ifdef RUN_CMD_STEP_EN
  typedef enum logic [2:0] {IDLE, GO_ADR, QUIT_EOL, ERR_EOL, STEP_EOL, STEP_QUIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, GO_ADR, QUIT_EOL, ERR_EOL} state_t;
`endif

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t      state;
  logic [31:0] acc;
  logic [3:0]  cnt;

  logic       is_term;
  logic       is_space;
  logic       is_hex;
  logic [3:0] nibble;
  logic [7:0] lower;

  always_comb begin
    is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    is_space = (rx_data == 8'h20);
    lower    = rx_data | 8'h20;
    is_hex   = 1'b0;
    nibble   = rx_data[3:0];
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
    end else if (lower >= 8'h61 && lower <= 8'h66) begin
      is_hex = 1'b1;
      nibble = rx_data[3:0] + 4'd9;
    end
  end

  assign parser_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      start_adr <= INIT_ADR[31:2];
      cpu_start <= 1'b0;
      quit_cmd  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cpu_start <= 1'b0;
      quit_cmd  <= 1'b0;
      cmd_err   <= 1'b0;
`ifdef RUN_CMD_STEP_EN
      // Second half of a step; a byte arriving now is decoded as if in IDLE.
      if (state == STEP_QUIT) begin
        quit_cmd <= 1'b1;
        state    <= IDLE;
      end
`endif
      if (rx_rdy) begin
        case (state)
`ifdef RUN_CMD_STEP_EN
          IDLE, STEP_QUIT: begin
`else
          IDLE: begin
`endif
            if (lower == 8'h67) begin
              state <= GO_ADR;
              acc   <= '0;
              cnt   <= '0;
            end else if (lower == 8'h71) begin
              state <= QUIT_EOL;
`ifdef RUN_CMD_STEP_EN
            end else if (lower == 8'h73) begin
              state <= STEP_EOL;
`endif
            end else if (is_space || is_term) begin
              state <= IDLE;
            end else begin
              state <= ERR_EOL;
            end
          end

          GO_ADR: begin
            if (is_term) begin
              state <= IDLE;
              if (cpu_run_state) begin
                cmd_err <= 1'b1;
              end else if (cnt != 4'd0 && acc[1:0] != 2'b00) begin
                cmd_err <= 1'b1;
              end else begin
                if (cnt != 4'd0) start_adr <= acc[31:2];
                cpu_start <= 1'b1;
              end
            end else if (is_hex) begin
              if (cnt == MAX_CNT) begin
                state <= ERR_EOL;
              end else begin
                acc <= {acc[27:0], nibble};
                cnt <= cnt + 4'd1;
              end
            end else if (is_space && cnt == 4'd0) begin
              state <= GO_ADR;
            end else begin
              state <= ERR_EOL;
            end
          end

          QUIT_EOL: begin
            if (is_term) begin
              state    <= IDLE;
              quit_cmd <= 1'b1;
            end else if (!is_space) begin
              state <= ERR_EOL;
            end
          end

`ifdef RUN_CMD_STEP_EN
          STEP_EOL: begin
            if (is_term) begin
              if (cpu_run_state) begin
                state   <= IDLE;
                cmd_err <= 1'b1;
              end else begin
                state     <= STEP_QUIT;
                cpu_start <= 1'b1;
              end
            end else if (!is_space) begin
              state <= ERR_EOL;
            end
          end
`endif

          ERR_EOL: begin
            if (is_term) begin
              state   <= IDLE;
              cmd_err <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_run_cmd_parser.sv
// Directed, table-driven bench for run_cmd_parser with hand sequences for
// busy, back-to-back, mid-command reset and (when enabled) step behaviour.
module tb_run_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        cpu_run_state;
  logic        cpu_start;
  logic        quit_cmd;
  logic [29:0] start_adr;
  logic        cmd_err;
  logic        parser_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  run_cmd_parser #(.INIT_ADR(32'h0000_0000), .MAX_DIGITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_rdy        (rx_rdy),
    .cpu_run_state (cpu_run_state),
    .cpu_start     (cpu_start),
    .quit_cmd      (quit_cmd),
    .start_adr     (start_adr),
    .cmd_err       (cmd_err),
    .parser_busy   (parser_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       cmd;
    logic        run;
    logic        exp_start;
    logic        exp_quit;
    logic        exp_err;
    logic [29:0] exp_adr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    string s;
    rst = 1'b1;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    cpu_run_state = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pulses", {29'd0, cpu_start, quit_cmd, cmd_err}, 32'd0);
    check("rst_busy", {31'd0, parser_busy}, 32'd0);
    check("rst_adr", {2'b00, start_adr}, 32'd0);
    rst = 1'b0;
    idle_cycle();

    vecs.push_back('{"g1000\015",       1'b0, 1'b1, 1'b0, 1'b0, 30'h400});
    vecs.push_back('{"q\n",             1'b1, 1'b0, 1'b1, 1'b0, 30'h400});
    vecs.push_back('{"g 1002\015",      1'b0, 1'b0, 1'b0, 1'b1, 30'h400});
    vecs.push_back('{"g\015",           1'b0, 1'b1, 1'b0, 1'b0, 30'h400});
    vecs.push_back('{"g123456789\015",  1'b0, 1'b0, 1'b0, 1'b1, 30'h400});
    vecs.push_back('{"x zz\015",        1'b0, 1'b0, 1'b0, 1'b1, 30'h400});
    vecs.push_back('{"g40\015",         1'b1, 1'b0, 1'b0, 1'b1, 30'h400});
    vecs.push_back('{"G  ABCDEF0C\015", 1'b0, 1'b1, 1'b0, 1'b0, 30'h2AF37BC3});
    vecs.push_back('{"g1 2\015",        1'b0, 1'b0, 1'b0, 1'b1, 30'h2AF37BC3});
    vecs.push_back('{"q x\015",         1'b0, 1'b0, 1'b0, 1'b1, 30'h2AF37BC3});
    vecs.push_back('{"Q \015",          1'b0, 1'b0, 1'b1, 1'b0, 30'h2AF37BC3});
`ifndef RUN_CMD_STEP_EN
    vecs.push_back('{"s\015",           1'b0, 1'b0, 1'b0, 1'b1, 30'h2AF37BC3});
`endif
    vecs.push_back('{"\015",            1'b0, 1'b0, 1'b0, 1'b0, 30'h2AF37BC3});
    vecs.push_back('{"g8\n",            1'b0, 1'b1, 1'b0, 1'b0, 30'h2});
    vecs.push_back('{"gz\015",          1'b0, 1'b0, 1'b0, 1'b1, 30'h2});

    for (int i = 0; i < vecs.size(); i++) begin
      cpu_run_state = vecs[i].run;
      for (int k = 0; k < vecs[i].cmd.len(); k++) begin
        send_byte(vecs[i].cmd[k]);
        if (k < vecs[i].cmd.len() - 1)
          check($sformatf("v%0d_nopulse_b%0d", i, k), {29'd0, cpu_start, quit_cmd, cmd_err}, 32'd0);
      end
      check($sformatf("v%0d_start", i), {31'd0, cpu_start}, {31'd0, vecs[i].exp_start});
      check($sformatf("v%0d_quit", i), {31'd0, quit_cmd}, {31'd0, vecs[i].exp_quit});
      check($sformatf("v%0d_err", i), {31'd0, cmd_err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_adr", i), {2'b00, start_adr}, {2'b00, vecs[i].exp_adr});
      check($sformatf("v%0d_busy_end", i), {31'd0, parser_busy}, 32'd0);
      idle_cycle();
      check($sformatf("v%0d_one_cycle", i), {29'd0, cpu_start, quit_cmd, cmd_err}, 32'd0);
    end

    // parser_busy spans first byte up to the terminator
    cpu_run_state = 1'b0;
    s = "x zz\015";
    for (int k = 0; k < s.len(); k++) begin
      send_byte(s[k]);
      if (k < s.len() - 1) check($sformatf("busy_b%0d", k), {31'd0, parser_busy}, 32'd1);
    end
    check("busy_err", {31'd0, cmd_err}, 32'd1);
    check("busy_low", {31'd0, parser_busy}, 32'd0);
    idle_cycle();

    // back-to-back bytes, 'g' arrives in the quit pulse cycle
    s = "q\015g10\015";
    for (int k = 0; k < s.len(); k++) begin
      send_byte(s[k]);
      if (k == 1) check("b2b_quit", {29'd0, cpu_start, quit_cmd, cmd_err}, 32'b010);
      if (k == 2) check("b2b_g_busy", {31'd0, parser_busy}, 32'd1);
    end
    check("b2b_start", {29'd0, cpu_start, quit_cmd, cmd_err}, 32'b100);
    check("b2b_adr", {2'b00, start_adr}, 32'h4);
    idle_cycle();

    // reset mid-command
    send_byte("g");
    send_byte("4");
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    check("mid_rst_pulses", {29'd0, cpu_start, quit_cmd, cmd_err}, 32'd0);
    check("mid_rst_busy", {31'd0, parser_busy}, 32'd0);
    check("mid_rst_adr", {2'b00, start_adr}, 32'd0);
    send_byte("q");
    send_byte(8'h0D);
    check("mid_rst_quit", {29'd0, cpu_start, quit_cmd, cmd_err}, 32'b010);
    check("mid_rst_adr2", {2'b00, start_adr}, 32'd0);
    idle_cycle();

`ifdef RUN_CMD_STEP_EN
    cpu_run_state = 1'b0;
    send_byte("s");
    send_byte(8'h0D);
    check("step_start", {29'd0, cpu_start, quit_cmd, cmd_err}, 32'b100);
    check("step_busy", {31'd0, parser_busy}, 32'd1);
    idle_cycle();
    check("step_quit", {29'd0, cpu_start, quit_cmd, cmd_err}, 32'b010);
    check("step_idle", {31'd0, parser_busy}, 32'd0);
    idle_cycle();
    cpu_run_state = 1'b1;
    send_byte("S");
    send_byte(8'h0A);
    check("step_running_err", {29'd0, cpu_start, quit_cmd, cmd_err}, 32'b001);
    idle_cycle();
    check("step_running_noquit", {29'd0, cpu_start, quit_cmd, cmd_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
